// File: rtl/pcie_s10_msi_mf.sv
// pcie_s10_msi_mf - multi-function MSI request generator for the Stratix 10
// app_msi interface.
//
// Each physical function has its own edge detector and pending register
// (pcie_s10_msi_mf_fn). Functions are served round-robin. Within a function,
// the lowest eligible vector wins. The grant is held on the hard IP req/ack
// handshake until it is acknowledged.
//
// Ports (top):
//   clk, rst_n                 clock, async active-low reset
//   msi_irq                    rising-edge interrupt inputs, bit f*MSI_COUNT+v
//   cfg_msi_enable             per-function MSI enable
//   cfg_multiple_msi_enable    per-function log2(allocated vectors), 3b each
//   cfg_msi_mask               per-function 32b vector mask
//   app_msi_req/ack            hard IP handshake
//   app_msi_tc                 constant traffic class
//   app_msi_num                folded vector number of the current request
//   app_msi_func_num           function of the current request
//   msi_pending                registered pending bits
//   msi_sent                   one-cycle pulse after an acknowledge
//   msi_sent_func/num          function / unfolded index of the sent message

// Per-function slice: edge detect, pending bits, folding, lowest-eligible pick.
//   irq       function's interrupt inputs
//   enable    MSI enable; while low, pending is flushed and edges are dropped
//   mme       log2 of the allocated vector count (values above 5 clamp to 5)
//   mask      per-vector mask, indexed by the folded number
//   clr       clear the pending bit clr_idx (acknowledge of this function)
//   pending   registered pending bits
//   any_elig  some vector is eligible
//   sel_idx   unfolded index of the lowest eligible vector
//   sel_num   folded number of that vector
module pcie_s10_msi_mf_fn #(
  parameter int MSI_COUNT = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [MSI_COUNT-1:0] irq,
  input  logic                 enable,
  input  logic [2:0]           mme,
  input  logic [31:0]          mask,
  input  logic                 clr,
  input  logic [4:0]           clr_idx,
  output logic [MSI_COUNT-1:0] pending,
  output logic                 any_elig,
  output logic [4:0]           sel_idx,
  output logic [4:0]           sel_num
);
  logic [MSI_COUNT-1:0]      irq_q, pend_q, rise, clr_vec, elig;
  logic [MSI_COUNT-1:0][4:0] fold_num;
  logic [2:0]                mme_c;
  logic [4:0]                alloc_mask;

  assign mme_c      = (mme > 3'd5) ? 3'd5 : mme;
  assign alloc_mask = 5'((6'd1 << mme_c) - 6'd1);
  // irq_q resets to 0, so a level already high at reset release is an edge
  assign rise       = irq & ~irq_q;

  always_comb begin
    clr_vec  = '0;
    elig     = '0;
    fold_num = '0;
    for (int v = 0; v < MSI_COUNT; v++) begin
      fold_num[v] = 5'(v) & alloc_mask;
      clr_vec[v]  = clr && (clr_idx == 5'(v));
      // masked vectors stay pending; they just cannot be picked
      elig[v]     = pend_q[v] && enable && !mask[fold_num[v]];
    end
  end

  // descending scan so the lowest eligible index is the last one written
  always_comb begin
    sel_idx = '0;
    sel_num = '0;
    for (int v = MSI_COUNT - 1; v >= 0; v--) begin
      if (elig[v]) begin
        sel_idx = 5'(v);
        sel_num = fold_num[v];
      end
    end
  end

  assign any_elig = |elig;
  assign pending  = pend_q;

  // set wins over clear: an edge landing in the ack cycle keeps the bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q  <= '0;
      pend_q <= '0;
    end else begin
      irq_q  <= irq;
      pend_q <= enable ? ((pend_q & ~clr_vec) | rise) : '0;
    end
  end
endmodule

module pcie_s10_msi_mf #(
  parameter int PF_COUNT  = 1,
  parameter int MSI_COUNT = 32,
  parameter int MSI_TC    = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PF_COUNT*MSI_COUNT-1:0] msi_irq,
  input  logic [PF_COUNT-1:0]           cfg_msi_enable,
  input  logic [PF_COUNT*3-1:0]         cfg_multiple_msi_enable,
  input  logic [PF_COUNT*32-1:0]        cfg_msi_mask,
  output logic                          app_msi_req,
  input  logic                          app_msi_ack,
  output logic [2:0]                    app_msi_tc,
  output logic [4:0]                    app_msi_num,
  output logic [1:0]                    app_msi_func_num,
  output logic [PF_COUNT*MSI_COUNT-1:0] msi_pending,
  output logic                          msi_sent,
  output logic [1:0]                    msi_sent_func,
  output logic [4:0]                    msi_sent_num
);
  typedef enum logic {IDLE, REQ} state_t;

  state_t          state, state_d;
  logic            load, ack_take;
  logic [1:0]      rr_ptr, grant_func, rr_nxt;
  logic [2:0]      rr_inc;
  logic [4:0]      grant_num, grant_idx;
  logic            sent_q;
  logic [1:0]      sent_func_q;
  logic [4:0]      sent_num_q;

  // per-function results padded to four entries so a 2-bit function number
  // always indexes them; unused entries are tied off
  logic [3:0]      any_elig;
  logic [3:0][4:0] sel_idx, sel_num;

  for (genvar f = 0; f < 4; f++) begin : g_fn
    if (f < PF_COUNT) begin : g_on
      pcie_s10_msi_mf_fn #(.MSI_COUNT(MSI_COUNT)) u_fn (
        .clk      (clk),
        .rst_n    (rst_n),
        .irq      (msi_irq[f*MSI_COUNT +: MSI_COUNT]),
        .enable   (cfg_msi_enable[f]),
        .mme      (cfg_multiple_msi_enable[f*3 +: 3]),
        .mask     (cfg_msi_mask[f*32 +: 32]),
        .clr      (ack_take && (grant_func == 2'(f))),
        .clr_idx  (grant_idx),
        .pending  (msi_pending[f*MSI_COUNT +: MSI_COUNT]),
        .any_elig (any_elig[f]),
        .sel_idx  (sel_idx[f]),
        .sel_num  (sel_num[f])
      );
    end else begin : g_off
      assign any_elig[f] = 1'b0;
      assign sel_idx[f]  = '0;
      assign sel_num[f]  = '0;
    end
  end

  // round-robin search starting at rr_ptr, wrapping at PF_COUNT
  logic       found;
  logic [1:0] pick_func;
  logic [4:0] pick_idx, pick_num;
  logic [2:0] rot;

  always_comb begin
    found     = 1'b0;
    pick_func = '0;
    pick_idx  = '0;
    pick_num  = '0;
    rot       = '0;
    for (int i = 0; i < PF_COUNT; i++) begin
      rot = {1'b0, rr_ptr} + 3'(i);
      if (rot >= 3'(PF_COUNT)) rot = rot - 3'(PF_COUNT);
      if (!found && any_elig[rot[1:0]]) begin
        found     = 1'b1;
        pick_func = rot[1:0];
        pick_idx  = sel_idx[rot[1:0]];
        pick_num  = sel_num[rot[1:0]];
      end
    end
  end

  assign rr_inc = {1'b0, grant_func} + 3'd1;
  assign rr_nxt = (rr_inc >= 3'(PF_COUNT)) ? 2'd0 : rr_inc[1:0];

  // REQ ignores enable/mask changes: once raised, the handshake must finish
  always_comb begin
    state_d  = state;
    load     = 1'b0;
    ack_take = 1'b0;
    case (state)
      IDLE: if (found) begin
        load    = 1'b1;
        state_d = REQ;
      end
      REQ: if (app_msi_ack) begin
        ack_take = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_func  <= '0;
      grant_num   <= '0;
      grant_idx   <= '0;
      sent_q      <= 1'b0;
      sent_func_q <= '0;
      sent_num_q  <= '0;
    end else begin
      state  <= state_d;
      sent_q <= ack_take;
      if (load) begin
        grant_func <= pick_func;
        grant_num  <= pick_num;
        grant_idx  <= pick_idx;
      end
      if (ack_take) begin
        rr_ptr      <= rr_nxt;
        sent_func_q <= grant_func;
        sent_num_q  <= grant_idx;
      end
    end
  end

  assign app_msi_req      = (state == REQ);
  assign app_msi_tc       = 3'(MSI_TC);
  assign app_msi_num      = grant_num;
  assign app_msi_func_num = grant_func;
  assign msi_sent         = sent_q;
  assign msi_sent_func    = sent_func_q;
  assign msi_sent_num     = sent_num_q;
endmodule

// File: tb/tb_pcie_s10_msi_mf.sv
// Bench for pcie_s10_msi_mf: four functions, 32 vectors each, TC=3.
// Inputs change on the falling edge; outputs are checked on the falling edge
// that follows each rising edge.
module tb_pcie_s10_msi_mf;
  localparam int PF = 4;
  localparam int MC = 32;
  localparam int TC = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [PF*MC-1:0] msi_irq;
  logic [PF-1:0]  cfg_msi_enable;
  logic [PF*3-1:0] cfg_multiple_msi_enable;
  logic [PF*32-1:0] cfg_msi_mask;
  logic           app_msi_req, app_msi_ack, msi_sent;
  logic [2:0]     app_msi_tc;
  logic [4:0]     app_msi_num, msi_sent_num;
  logic [1:0]     app_msi_func_num, msi_sent_func;
  logic [PF*MC-1:0] msi_pending;

  pcie_s10_msi_mf #(.PF_COUNT(PF), .MSI_COUNT(MC), .MSI_TC(TC)) dut (
    .clk(clk), .rst_n(rst_n), .msi_irq(msi_irq),
    .cfg_msi_enable(cfg_msi_enable),
    .cfg_multiple_msi_enable(cfg_multiple_msi_enable),
    .cfg_msi_mask(cfg_msi_mask),
    .app_msi_req(app_msi_req), .app_msi_ack(app_msi_ack),
    .app_msi_tc(app_msi_tc), .app_msi_num(app_msi_num),
    .app_msi_func_num(app_msi_func_num), .msi_pending(msi_pending),
    .msi_sent(msi_sent), .msi_sent_func(msi_sent_func),
    .msi_sent_num(msi_sent_num)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // function-0 vectors: inputs for one cycle, expected outputs after the edge
  typedef struct {
    logic [31:0] irq;
    logic [2:0]  mme;
    logic [31:0] mask;
    logic        ack;
    logic        e_req;
    logic [4:0]  e_num;
    logic [31:0] e_pend;
    logic        e_sent;
    logic [4:0]  e_snum;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic [31:0] irq, input logic [2:0] mme,
                     input logic [31:0] mask, input logic ack, input logic req,
                     input logic [4:0] num, input logic [31:0] pend,
                     input logic sent, input logic [4:0] snum);
    vq.push_back('{irq, mme, mask, ack, req, num, pend, sent, snum});
  endtask

  initial begin
    int req_cnt, sent_cnt, bad;

    // single vector 3
    add(32'h0,        3'd5, 32'h0,  1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0);
    add(32'h8,        3'd5, 32'h0,  1'b0, 1'b0, 5'd0,  32'h8,        1'b0, 5'd0);
    add(32'h0,        3'd5, 32'h0,  1'b0, 1'b1, 5'd3,  32'h8,        1'b0, 5'd0);
    add(32'h0,        3'd5, 32'h0,  1'b0, 1'b1, 5'd3,  32'h8,        1'b0, 5'd0);
    add(32'h0,        3'd5, 32'h0,  1'b0, 1'b1, 5'd3,  32'h8,        1'b0, 5'd0);
    add(32'h0,        3'd5, 32'h0,  1'b1, 1'b0, 5'd0,  32'h0,        1'b1, 5'd3);
    add(32'h0,        3'd5, 32'h0,  1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0);
    // masked vector 5, then unmask
    add(32'h20,       3'd5, 32'h20, 1'b0, 1'b0, 5'd0,  32'h20,       1'b0, 5'd0);
    add(32'h0,        3'd5, 32'h20, 1'b0, 1'b0, 5'd0,  32'h20,       1'b0, 5'd0);
    add(32'h0,        3'd5, 32'h0,  1'b0, 1'b1, 5'd5,  32'h20,       1'b0, 5'd0);
    add(32'h0,        3'd5, 32'h0,  1'b1, 1'b0, 5'd0,  32'h0,        1'b1, 5'd5);
    // folding with two vectors: 6 -> 0
    add(32'h40,       3'd1, 32'h0,  1'b0, 1'b0, 5'd0,  32'h40,       1'b0, 5'd0);
    add(32'h0,        3'd1, 32'h0,  1'b0, 1'b1, 5'd0,  32'h40,       1'b0, 5'd0);
    add(32'h0,        3'd1, 32'h0,  1'b1, 1'b0, 5'd0,  32'h0,        1'b1, 5'd6);
    // folded mask bit 0 blocks vector 6; mask bit 6 does not
    add(32'h40,       3'd1, 32'h1,  1'b0, 1'b0, 5'd0,  32'h40,       1'b0, 5'd0);
    add(32'h0,        3'd1, 32'h1,  1'b0, 1'b0, 5'd0,  32'h40,       1'b0, 5'd0);
    add(32'h0,        3'd1, 32'h40, 1'b0, 1'b1, 5'd0,  32'h40,       1'b0, 5'd0);
    add(32'h0,        3'd1, 32'h40, 1'b1, 1'b0, 5'd0,  32'h0,        1'b1, 5'd6);
    // lowest index first, then the next one
    add(32'h102,      3'd5, 32'h0,  1'b0, 1'b0, 5'd0,  32'h102,      1'b0, 5'd0);
    add(32'h0,        3'd5, 32'h0,  1'b0, 1'b1, 5'd1,  32'h102,      1'b0, 5'd0);
    add(32'h0,        3'd5, 32'h0,  1'b1, 1'b0, 5'd0,  32'h100,      1'b1, 5'd1);
    add(32'h0,        3'd5, 32'h0,  1'b0, 1'b1, 5'd8,  32'h100,      1'b0, 5'd0);
    add(32'h0,        3'd5, 32'h0,  1'b1, 1'b0, 5'd0,  32'h0,        1'b1, 5'd8);
    // mme above 5 clamps to 32 vectors
    add(32'h8000_0000, 3'd7, 32'h0, 1'b0, 1'b0, 5'd0,  32'h8000_0000, 1'b0, 5'd0);
    add(32'h0,        3'd7, 32'h0,  1'b0, 1'b1, 5'd31, 32'h8000_0000, 1'b0, 5'd0);
    add(32'h0,        3'd7, 32'h0,  1'b1, 1'b0, 5'd0,  32'h0,        1'b1, 5'd31);

    // reset state
    rst_n = 1'b0;
    msi_irq = '0;
    cfg_msi_enable = 4'hF;
    cfg_multiple_msi_enable = {3'd5, 3'd5, 3'd5, 3'd5};
    cfg_msi_mask = '0;
    app_msi_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req", 64'(app_msi_req), 64'd0);
    chk("rst_tc", 64'(app_msi_tc), 64'(TC));
    chk("rst_num", 64'({app_msi_func_num, app_msi_num}), 64'd0);
    chk("rst_pend_lo", msi_pending[63:0], 64'd0);
    chk("rst_pend_hi", msi_pending[127:64], 64'd0);
    chk("rst_sent", 64'({msi_sent, msi_sent_func, msi_sent_num}), 64'd0);
    rst_n = 1'b1;
    cyc();

    // round-robin: vector 0 of every function at once, ack held high
    msi_irq = '0;
    for (int f = 0; f < PF; f++) msi_irq[f*MC] = 1'b1;
    cyc();
    msi_irq = '0;
    app_msi_ack = 1'b1;
    chk("rr_pend", 64'({msi_pending[96], msi_pending[64], msi_pending[32], msi_pending[0]}), 64'hF);
    req_cnt = 0;
    sent_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      cyc();
      if (app_msi_req) begin
        chk($sformatf("rr_func%0d", req_cnt), 64'(app_msi_func_num), 64'(req_cnt));
        chk($sformatf("rr_cycle%0d", req_cnt), 64'(c), 64'(2 * req_cnt));
        req_cnt++;
      end
      if (msi_sent) begin
        chk($sformatf("rr_sent_func%0d", sent_cnt), 64'(msi_sent_func), 64'(sent_cnt));
        sent_cnt++;
      end
    end
    chk("rr_req_count", 64'(req_cnt), 64'd4);
    chk("rr_sent_count", 64'(sent_cnt), 64'd4);
    app_msi_ack = 1'b0;

    // table on function 0 only
    cfg_msi_enable = 4'b0001;
    for (int i = 0; i < vq.size(); i++) begin
      msi_irq = {96'b0, vq[i].irq};
      cfg_multiple_msi_enable = {9'b0, vq[i].mme};
      cfg_msi_mask = {96'b0, vq[i].mask};
      app_msi_ack = vq[i].ack;
      cyc();
      chk($sformatf("vec%0d_req", i), 64'(app_msi_req), 64'(vq[i].e_req));
      chk($sformatf("vec%0d_pend", i), 64'(msi_pending[31:0]), 64'(vq[i].e_pend));
      chk($sformatf("vec%0d_sent", i), 64'(msi_sent), 64'(vq[i].e_sent));
      if (vq[i].e_req)
        chk($sformatf("vec%0d_num", i), 64'({app_msi_func_num, app_msi_num}), 64'(vq[i].e_num));
      if (vq[i].e_sent)
        chk($sformatf("vec%0d_snum", i), 64'({msi_sent_func, msi_sent_num}), 64'(vq[i].e_snum));
    end
    app_msi_ack = 1'b0;
    msi_irq = '0;
    cfg_multiple_msi_enable = {9'b0, 3'd5};
    cfg_msi_mask = '0;

    // masked vector stays pending without a request for 50 cycles
    cfg_msi_mask[5] = 1'b1;
    msi_irq[5] = 1'b1;
    cyc();
    msi_irq = '0;
    bad = 0;
    repeat (50) begin
      cyc();
      if (app_msi_req) bad++;
    end
    chk("mask_no_req", 64'(bad), 64'd0);
    chk("mask_pend", 64'(msi_pending[5]), 64'd1);
    cfg_msi_mask = '0;
    cyc();
    chk("unmask_req", 64'({app_msi_req, app_msi_num}), 64'({1'b1, 5'd5}));
    app_msi_ack = 1'b1;
    cyc();
    app_msi_ack = 1'b0;
    chk("unmask_sent", 64'({msi_sent, msi_sent_num}), 64'({1'b1, 5'd5}));

    // set wins: new edge on vector 2 lands in its ack cycle
    msi_irq[2] = 1'b1;
    cyc();
    msi_irq = '0;
    cyc();
    chk("sw_req1", 64'({app_msi_req, app_msi_num}), 64'({1'b1, 5'd2}));
    msi_irq[2] = 1'b1;
    app_msi_ack = 1'b1;
    cyc();
    msi_irq = '0;
    app_msi_ack = 1'b0;
    chk("sw_sent1", 64'({app_msi_req, msi_sent, msi_sent_num}), 64'({1'b0, 1'b1, 5'd2}));
    chk("sw_still_pend", 64'(msi_pending[2]), 64'd1);
    cyc();
    chk("sw_req2", 64'({app_msi_req, app_msi_num}), 64'({1'b1, 5'd2}));
    app_msi_ack = 1'b1;
    cyc();
    app_msi_ack = 1'b0;
    chk("sw_sent2", 64'({msi_sent, msi_sent_num}), 64'({1'b1, 5'd2}));
    chk("sw_pend_clr", 64'(msi_pending[31:0]), 64'd0);

    // held level: one message in 100 cycles
    msi_irq[4] = 1'b1;
    app_msi_ack = 1'b1;
    sent_cnt = 0;
    repeat (100) begin
      cyc();
      if (msi_sent) sent_cnt++;
    end
    chk("held_one_msg", 64'(sent_cnt), 64'd1);
    msi_irq = '0;
    app_msi_ack = 1'b0;
    repeat (3) cyc();
    chk("held_quiet", 64'({app_msi_req, msi_pending[31:0]}), 64'd0);

    // disable function 1 with masked pending bits
    cfg_msi_enable = 4'b0011;
    cfg_msi_mask[63:32] = 32'hFFFF_FFFF;
    msi_irq[33] = 1'b1;
    msi_irq[34] = 1'b1;
    cyc();
    msi_irq = '0;
    cyc();
    chk("dis_pend_set", 64'(msi_pending[63:32]), 64'h6);
    chk("dis_no_req", 64'(app_msi_req), 64'd0);
    cfg_msi_enable = 4'b0001;
    cyc();
    chk("dis_pend_clr", 64'(msi_pending[63:32]), 64'h0);
    msi_irq[35] = 1'b1;
    cyc();
    msi_irq = '0;
    chk("dis_edge_ignored", 64'(msi_pending[63:32]), 64'h0);
    cfg_msi_mask = '0;

    // reset during REQ, with irq[7] held high across release
    msi_irq[7] = 1'b1;
    cyc();
    cyc();
    chk("rq_req", 64'({app_msi_req, app_msi_num}), 64'({1'b1, 5'd7}));
    #2 rst_n = 1'b0;
    #1;
    chk("rq_req_drop", 64'(app_msi_req), 64'd0);
    chk("rq_num", 64'({app_msi_func_num, app_msi_num}), 64'd0);
    chk("rq_pend", msi_pending[63:0], 64'd0);
    chk("rq_sent", 64'({msi_sent, msi_sent_func, msi_sent_num}), 64'd0);
    chk("rq_tc", 64'(app_msi_tc), 64'(TC));
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("rel_level_edge", 64'(msi_pending[31:0]), 64'h80);
    cyc();
    chk("rel_req", 64'({app_msi_req, app_msi_num}), 64'({1'b1, 5'd7}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
